// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping bus: bus commands, arbiter FSM states and MESI codes.
package snoop_bus_pkg;

  typedef enum logic [1:0] {
    CMD_RD_MISS = 2'd0,
    CMD_WR_MISS = 2'd1,
    CMD_INV     = 2'd2,
    CMD_NONE    = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BCAST,
    ST_SNOOP,
    ST_WB,
    ST_MEM_RD,
    ST_MEM_CAP,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_M = 2'd2,
    MESI_E = 2'd3
  } mesi_t;

  // NONE carries no data movement, so it completes like an invalidate.
  function automatic logic cmd_skips_mem(input bus_cmd_t cmd);
    return (cmd == CMD_INV) || (cmd == CMD_NONE);
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Request arbiter: one-hot grant plus index. Round-robin from i_ptr by default;
// ARB_FIXED_PRIORITY_EN builds a fixed lowest-index-wins arbiter with no pointer port.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
`ifndef ARB_FIXED_PRIORITY_EN
  input  logic [IDX_W-1:0] i_ptr,
`endif
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

`ifndef ARB_FIXED_PRIORITY_EN
  int               w_pos;
  logic [IDX_W-1:0] w_cand;
`endif

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant = '0;
        o_grant[i] = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
`else
    w_pos  = 0;
    w_cand = '0;
    // Scan from the far end back toward i_ptr so the nearest requester is written last.
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = IDX_W'(w_pos);
      if (i_req[w_cand]) begin
        o_grant = '0;
        o_grant[w_cand] = 1'b1;
        o_idx = w_cand;
      end
    end
`endif
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus owner: arbitration, per-transaction sequencing and memory port muxing.
// Build option ARB_FIXED_PRIORITY_EN: fixed lowest-index priority instead of round-robin.
// state | meaning: IDLE arbitrate | BCAST command on bus | SNOOP collect responses |
//   WB dirty write-back | MEM_RD address memory | MEM_CAP capture read data | DONE pulse owner
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int N_PROC     = 3,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int SNOOP_WAIT = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_PROC-1:0]        i_req,
  input  logic [2*N_PROC-1:0]      i_req_cmd,
  input  logic [ADDR_W*N_PROC-1:0] i_req_addr,
  input  logic [N_PROC-1:0]        i_snoop_abort,
  input  logic [N_PROC-1:0]        i_snoop_shared,
  input  logic [DATA_W*N_PROC-1:0] i_wb_data,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  output logic [N_PROC-1:0]        o_snooping,
  output logic                     o_bus_valid,
  output bus_cmd_t                 o_bus_cmd,
  output logic [ADDR_W-1:0]        o_bus_addr,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  output logic [N_PROC-1:0]        o_done,
  output logic [DATA_W-1:0]        o_fill_data,
  output logic                     o_fill_shared,
  output logic                     o_proto_err
);

  localparam int IDX_W  = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int WAIT_W = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;

  arb_state_t          r_state;
  bus_cmd_t            r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [N_PROC-1:0]   r_abort_v;
  logic                r_shared;
  logic [WAIT_W-1:0]   r_wait;
`ifndef ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_rr_ptr;
`endif
  logic [N_PROC-1:0]   r_snooping;
  logic                r_bus_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [N_PROC-1:0]   r_done;
  logic [DATA_W-1:0]   r_fill_data;
  logic                r_fill_shared;
  logic                r_proto_err;

  logic [N_PROC-1:0]   w_gnt;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [N_PROC-1:0]   w_abort_now;
  logic                w_shared_now;
  logic [DATA_W-1:0]   w_wb_sel;
  logic                w_multi_abort;
  logic                w_seen_abort;

  rr_arbiter #(.N(N_PROC), .IDX_W(IDX_W)) u_arb (
    .i_req   (i_req),
`ifndef ARB_FIXED_PRIORITY_EN
    .i_ptr   (r_rr_ptr),
`endif
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx)
  );

  // While a transaction is open r_snooping is ~onehot(owner), so it doubles as the owner mask.
  assign w_abort_now  = r_abort_v | (i_snoop_abort & r_snooping);
  assign w_shared_now = r_shared | (|(i_snoop_shared & r_snooping));

  always_comb begin
    w_wb_sel      = '0;
    w_multi_abort = 1'b0;
    w_seen_abort  = 1'b0;
    for (int i = 0; i < N_PROC; i++) begin
      if (w_abort_now[i]) begin
        if (w_seen_abort) w_multi_abort = 1'b1;
        else              w_wb_sel = i_wb_data[i*DATA_W +: DATA_W];
        w_seen_abort = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cmd         <= CMD_RD_MISS;
      r_addr        <= '0;
      r_abort_v     <= '0;
      r_shared      <= 1'b0;
      r_wait        <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      r_owner       <= '0;
      r_rr_ptr      <= '0;
`endif
      r_snooping    <= '1;
      r_bus_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_done        <= '0;
      r_fill_data   <= '0;
      r_fill_shared <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_bus_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_done        <= '0;
      r_fill_shared <= 1'b0;
      r_proto_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
`ifndef ARB_FIXED_PRIORITY_EN
            r_owner     <= w_gnt_idx;
`endif
            r_cmd       <= bus_cmd_t'(i_req_cmd[w_gnt_idx*2 +: 2]);
            r_addr      <= i_req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_abort_v   <= '0;
            r_shared    <= 1'b0;
            r_wait      <= WAIT_W'(SNOOP_WAIT - 1);
            r_snooping  <= ~w_gnt;
            r_bus_valid <= 1'b1;
            r_state     <= ST_BCAST;
          end
        end
        ST_BCAST: r_state <= ST_SNOOP;
        ST_SNOOP: begin
          r_abort_v <= w_abort_now;
          r_shared  <= w_shared_now;
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else if (|w_abort_now) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_wb_sel;
            r_proto_err <= w_multi_abort;
            r_state     <= ST_WB;
          end else if (cmd_skips_mem(r_cmd)) begin
            r_done  <= ~r_snooping;
            r_state <= ST_DONE;
          end else begin
            r_mem_addr <= r_addr;
            r_state    <= ST_MEM_RD;
          end
        end
        ST_WB: begin
          if (cmd_skips_mem(r_cmd)) begin
            r_done  <= ~r_snooping;
            r_state <= ST_DONE;
          end else begin
            r_mem_addr <= r_addr;
            r_state    <= ST_MEM_RD;
          end
        end
        ST_MEM_RD: r_state <= ST_MEM_CAP;
        ST_MEM_CAP: begin
          r_fill_data   <= i_mem_rdata;
          r_fill_shared <= r_shared && (r_cmd == CMD_RD_MISS);
          r_done        <= ~r_snooping;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
`ifndef ARB_FIXED_PRIORITY_EN
          if (r_owner == IDX_W'(N_PROC - 1)) r_rr_ptr <= '0;
          else                               r_rr_ptr <= r_owner + 1'b1;
`endif
          r_snooping <= '1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_snooping    = r_snooping;
  assign o_bus_valid   = r_bus_valid;
  assign o_bus_cmd     = r_cmd;
  assign o_bus_addr    = r_addr;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_done        = r_done;
  assign o_fill_data   = r_fill_data;
  assign o_fill_shared = r_fill_shared;
  assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: completions go through an expected-response queue
// checked by an independent monitor; bus/memory side effects are checked inline.
module tb_snoop_bus_arbiter;
  import snoop_bus_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req, abort_v, shared_v;
  logic [2*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] wb_data;
  logic [DW-1:0]   mem_rdata;

  logic [N-1:0]    o_snooping, o_done;
  logic            o_bus_valid, o_mem_we, o_fill_shared, o_proto_err;
  bus_cmd_t        o_bus_cmd;
  logic [AW-1:0]   o_bus_addr, o_mem_addr;
  logic [DW-1:0]   o_mem_wdata, o_fill_data;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] fill;
    logic          shared;
    logic          chk_fill;
    int            cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [DW-1:0] mem [32];

  snoop_bus_arbiter dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req          (req),
    .i_req_cmd      (req_cmd),
    .i_req_addr     (req_addr),
    .i_snoop_abort  (abort_v),
    .i_snoop_shared (shared_v),
    .i_wb_data      (wb_data),
    .i_mem_rdata    (mem_rdata),
    .o_snooping     (o_snooping),
    .o_bus_valid    (o_bus_valid),
    .o_bus_cmd      (o_bus_cmd),
    .o_bus_addr     (o_bus_addr),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_done         (o_done),
    .o_fill_data    (o_fill_data),
    .o_fill_shared  (o_fill_shared),
    .o_proto_err    (o_proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: one-cycle read latency, write visible to the next read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem[5'h0A] <= 8'h3C;
      mem[5'h01] <= 8'hA1;
      mem[5'h02] <= 8'hB2;
      mem[5'h03] <= 8'hC3;
      mem_rdata  <= '0;
    end else begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      mem_rdata <= mem[o_mem_addr];
    end
  end

  always @(negedge clk) begin
    if (o_done != '0) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got done=%b at cycle %0d, want none", o_done, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (o_done !== mon_e.done || cyc != mon_e.cyc || o_fill_shared !== mon_e.shared ||
            (mon_e.chk_fill && o_fill_data !== mon_e.fill)) begin
          n_err++;
          $display("FAIL done_resp: got done=%b cyc=%0d fill=%h sh=%b, want done=%b cyc=%0d fill=%h sh=%b",
                   o_done, cyc, o_fill_data, o_fill_shared,
                   mon_e.done, mon_e.cyc, mon_e.fill, mon_e.shared);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_done(input int p, input logic [DW-1:0] fill, input logic sh,
                             input logic cf, input int lat);
    exp_t e;
    e.done     = '0;
    e.done[p]  = 1'b1;
    e.fill     = fill;
    e.shared   = sh;
    e.chk_fill = cf;
    e.cyc      = cyc + lat;
    sb_q.push_back(e);
  endtask

  task automatic issue(input int p, input bus_cmd_t c, input logic [AW-1:0] a);
    req[p] = 1'b1;
    req_cmd[p*2 +: 2] = c;
    req_addr[p*AW +: AW] = a;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_done == '0 && t < 40);
    n_vec++;
    if (o_done == '0) begin
      n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles, want a done pulse", t);
    end
  endtask

  task automatic idle_inputs();
    req      = '0;
    abort_v  = '0;
    shared_v = '0;
    wb_data  = '0;
    @(negedge clk);
  endtask

  initial begin
    req = '0; abort_v = '0; shared_v = '0;
    req_cmd = '0; req_addr = '0; wb_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_state", {o_snooping, o_done, o_bus_valid, o_mem_we, o_proto_err, o_fill_shared},
          {3'b111, 3'b000, 4'b0000});
    end

    // P0 RD_MISS 0A, no snoop response
    expect_done(0, 8'h3C, 1'b0, 1'b1, 5);
    issue(0, CMD_RD_MISS, 5'h0A);
    @(negedge clk);
    chk("bcast_p0", {o_bus_valid, o_bus_cmd, o_bus_addr, o_snooping}, {1'b1, 2'd0, 5'h0A, 3'b110});
    wait_done();
    idle_inputs();

    // P1 WR_MISS 11, P2 aborts with dirty 77
    expect_done(1, 8'h77, 1'b0, 1'b1, 6);
    issue(1, CMD_WR_MISS, 5'h11);
    abort_v[2] = 1'b1;
    wb_data[2*DW +: DW] = 8'h77;
    @(negedge clk);
    chk("bcast_p1", {o_bus_valid, o_bus_cmd, o_bus_addr, o_snooping}, {1'b1, 2'd1, 5'h11, 3'b101});
    repeat (2) @(negedge clk);
    chk("wb_p2", {o_mem_we, o_mem_addr, o_mem_wdata, o_proto_err}, {1'b1, 5'h11, 8'h77, 1'b0});
    wait_done();
    idle_inputs();

    // P1 RD_MISS with P0 sharing; owner's own abort must be masked
    expect_done(1, 8'h3C, 1'b1, 1'b1, 5);
    issue(1, CMD_RD_MISS, 5'h0A);
    shared_v[0] = 1'b1;
    abort_v[1]  = 1'b1;
    repeat (3) @(negedge clk);
    chk("owner_abort_masked", {31'd0, o_mem_we}, 32'd0);
    wait_done();
    idle_inputs();

    // P2 INV with P0 sharing: no memory access, fill_shared stays 0
    expect_done(2, 8'h00, 1'b0, 1'b0, 3);
    issue(2, CMD_INV, 5'h04);
    shared_v[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("inv_no_mem", {31'd0, o_mem_we}, 32'd0);
    end
    wait_done();
    idle_inputs();

    // All three request continuously for three transactions
`ifdef ARB_FIXED_PRIORITY_EN
    expect_done(0, 8'hA1, 1'b0, 1'b1, 5);
    expect_done(0, 8'hA1, 1'b0, 1'b1, 11);
    expect_done(0, 8'hA1, 1'b0, 1'b1, 17);
`else
    expect_done(0, 8'hA1, 1'b0, 1'b1, 5);
    expect_done(1, 8'hB2, 1'b0, 1'b1, 11);
    expect_done(2, 8'hC3, 1'b0, 1'b1, 17);
`endif
    issue(0, CMD_RD_MISS, 5'h01);
    issue(1, CMD_RD_MISS, 5'h02);
    issue(2, CMD_RD_MISS, 5'h03);
    repeat (3) wait_done();
    idle_inputs();

    // Reset asserted during the write-back cycle
    issue(1, CMD_RD_MISS, 5'h08);
    abort_v[2] = 1'b1;
    wb_data[2*DW +: DW] = 8'hEE;
    repeat (3) @(negedge clk);
    chk("wb_before_reset", {31'd0, o_mem_we}, 32'd1);
    rst = 1'b1;
    req = '0; abort_v = '0; wb_data = '0;
    @(negedge clk);
    chk("reset_mid_wb", {o_mem_we, o_done, o_snooping, o_bus_valid}, {1'b0, 3'b000, 3'b111, 1'b0});
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // P0 and P2 both abort: protocol error, lowest index data written
    expect_done(1, 8'h99, 1'b0, 1'b1, 6);
    issue(1, CMD_WR_MISS, 5'h12);
    abort_v[0] = 1'b1;
    abort_v[2] = 1'b1;
    wb_data[0*DW +: DW] = 8'h99;
    wb_data[2*DW +: DW] = 8'h55;
    repeat (3) @(negedge clk);
    chk("wb_multi_abort", {o_mem_we, o_mem_addr, o_mem_wdata, o_proto_err}, {1'b1, 5'h12, 8'h99, 1'b1});
    @(negedge clk);
    chk("proto_err_pulse", {31'd0, o_proto_err}, 32'd0);
    wait_done();
    idle_inputs();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end

endmodule
